// File: rtl/rxq_multi_arbiter.sv
// Multi-channel receive queue: one FIFO per source, round-robin drain into a registered valid/ready output.
// Define RXQ_BYPASS_EN to let a push into an all-empty queue load the output on the same edge.
module rxq_multi_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SRC_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         check,
  input  logic [NCH*WIDTH-1:0]   in_sig,
  input  logic                   proc_ready,
  input  logic                   clr_ovf,
  output logic [WIDTH-1:0]       selected_sig,
  output logic                   sig_alert,
  output logic [SRC_W-1:0]       s,
  output logic [NCH-1:0]         overflow,
  output logic [NCH-1:0]         fifo_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [NCH][DEPTH];
  logic [WIDTH-1:0] mem_d [NCH][DEPTH];
  logic [PW-1:0]    wr_q  [NCH];
  logic [PW-1:0]    wr_d  [NCH];
  logic [PW-1:0]    rd_q  [NCH];
  logic [PW-1:0]    rd_d  [NCH];

  logic [NCH-1:0]   ovf_q, ovf_d;
  logic [NCH-1:0]   fe_q, fe_d;
  logic [WIDTH-1:0] sel_q, sel_d;
  logic [SRC_W-1:0] s_q, s_d;
  logic [SRC_W-1:0] lg_q, lg_d;
  logic             alert_q, alert_d;

  logic [NCH-1:0]   empty_c, full_c, pop_c, push_c;
  logic [SRC_W-1:0] grant_c, idx_c;
  logic             found_c, load_c;
`ifdef RXQ_BYPASS_EN
  logic [SRC_W-1:0] byp_c;
  logic             byp_found_c;
`endif

  // Extra pointer bit distinguishes full from empty when the index bits match.
  always_comb begin
    empty_c = '0;
    full_c  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      empty_c[i] = (wr_q[i] == rd_q[i]);
      full_c[i]  = (wr_q[i][AW] != rd_q[i][AW]) && (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    found_c = 1'b0;
    grant_c = '0;
    idx_c   = '0;
`ifdef RXQ_BYPASS_EN
    byp_found_c = 1'b0;
    byp_c       = '0;
`endif
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx_c = SRC_W'((32'(lg_q) + k) % NCH);
      for (int unsigned i = 0; i < NCH; i++) begin
        if (idx_c == SRC_W'(i)) begin
          if (!found_c && !empty_c[i]) begin
            found_c = 1'b1;
            grant_c = idx_c;
          end
`ifdef RXQ_BYPASS_EN
          if (!byp_found_c && check[i]) begin
            byp_found_c = 1'b1;
            byp_c       = idx_c;
          end
`endif
        end
      end
    end
  end

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = clr_ovf ? '0 : ovf_q;
    sel_d   = sel_q;
    s_d     = s_q;
    lg_d    = lg_q;
    alert_d = alert_q;
    pop_c   = '0;
    push_c  = check;
    fe_d    = '0;
    load_c  = !alert_q || proc_ready;

    if (load_c) begin
      alert_d = 1'b0;
      if (found_c) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (grant_c == SRC_W'(i)) begin
            pop_c[i] = 1'b1;
            sel_d    = mem_q[i][rd_q[i][AW-1:0]];
          end
        end
        s_d     = grant_c;
        lg_d    = grant_c;
        alert_d = 1'b1;
      end
`ifdef RXQ_BYPASS_EN
      // Empty queue: the winning push skips its FIFO and lands in the output register.
      else if (byp_found_c) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (byp_c == SRC_W'(i)) begin
            push_c[i] = 1'b0;
            sel_d     = in_sig[i*WIDTH +: WIDTH];
          end
        end
        s_d     = byp_c;
        lg_d    = byp_c;
        alert_d = 1'b1;
      end
`endif
    end

    // A full FIFO still accepts a push when its head leaves on the same edge; a drop beats clr_ovf.
    for (int unsigned i = 0; i < NCH; i++) begin
      if (push_c[i]) begin
        if (!full_c[i] || pop_c[i]) begin
          mem_d[i][wr_q[i][AW-1:0]] = in_sig[i*WIDTH +: WIDTH];
          wr_d[i] = wr_q[i] + PW'(1);
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
      if (pop_c[i]) begin
        rd_d[i] = rd_q[i] + PW'(1);
      end
      fe_d[i] = (wr_d[i] == rd_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wr_q    <= '{default: '0};
      rd_q    <= '{default: '0};
      ovf_q   <= '0;
      fe_q    <= '1;
      sel_q   <= '0;
      s_q     <= '0;
      lg_q    <= SRC_W'(NCH - 1);
      alert_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      fe_q    <= fe_d;
      sel_q   <= sel_d;
      s_q     <= s_d;
      lg_q    <= lg_d;
      alert_q <= alert_d;
    end
  end

  assign selected_sig = sel_q;
  assign sig_alert    = alert_q;
  assign s            = s_q;
  assign overflow     = ovf_q;
  assign fifo_empty   = fe_q;

endmodule

// File: tb/tb_rxq_multi_arbiter.sv
// Directed bench for rxq_multi_arbiter: cycle checks plus an in-order scoreboard of delivered instructions.
module tb_rxq_multi_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NCH   = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SRC_W = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NCH-1:0]       check;
  logic [NCH*WIDTH-1:0] in_sig;
  logic                 proc_ready;
  logic                 clr_ovf;
  logic [WIDTH-1:0]     selected_sig;
  logic                 sig_alert;
  logic [SRC_W-1:0]     s;
  logic [NCH-1:0]       overflow;
  logic [NCH-1:0]       fifo_empty;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SRC_W-1:0] s;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  rxq_multi_arbiter #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .SRC_W(SRC_W)) dut (
    .clk(clk), .rst_n(rst_n), .check(check), .in_sig(in_sig),
    .proc_ready(proc_ready), .clr_ovf(clr_ovf),
    .selected_sig(selected_sig), .sig_alert(sig_alert), .s(s),
    .overflow(overflow), .fifo_empty(fifo_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic [WIDTH-1:0] v);
    check[ch] = 1'b1;
    in_sig[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic expect_out(input logic [WIDTH-1:0] d, input int src);
    exp_t e;
    e.d = d;
    e.s = SRC_W'(src);
    sb_q.push_back(e);
  endtask

  task automatic wait_alert(input string tag, input int max_cycles);
    int n = 0;
    while (!sig_alert && n < max_cycles) begin
      tick();
      n++;
    end
    chk(tag, 64'(sig_alert), 64'(1));
  endtask

  // Every accepted handshake must match the next expected instruction in order.
  always @(negedge clk) begin
    if (rst_n && sig_alert && proc_ready) begin
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("sb_data", 64'(selected_sig), 64'(mon_e.d));
        chk("sb_src", 64'(s), 64'(mon_e.s));
      end
    end
  end

  initial begin
    rst_n = 1'b1; check = '0; in_sig = '0; proc_ready = 1'b0; clr_ovf = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_alert", 64'(sig_alert), 64'(0));
    chk("rst_sel", 64'(selected_sig), 64'(0));
    chk("rst_s", 64'(s), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_empty", 64'(fifo_empty), 64'(3'b111));
    tick();
    rst_n = 1'b1;
    tick();

    // Single push on ch0.
    proc_ready = 1'b1;
    drive(0, 32'd42);
    expect_out(32'd42, 0);
    tick();
    check = '0;
`ifdef RXQ_BYPASS_EN
    chk("t1_alert_e1", 64'(sig_alert), 64'(1));
    chk("t1_sel", 64'(selected_sig), 64'(42));
    chk("t1_s", 64'(s), 64'(0));
`else
    chk("t1_alert_e1", 64'(sig_alert), 64'(0));
    chk("t1_empty_e1", 64'(fifo_empty), 64'(3'b110));
    tick();
    chk("t1_alert_e2", 64'(sig_alert), 64'(1));
    chk("t1_sel", 64'(selected_sig), 64'(42));
    chk("t1_s", 64'(s), 64'(0));
`endif
    tick();
    chk("t1_alert_drop", 64'(sig_alert), 64'(0));

    // Two channels pushed together drain on consecutive cycles.
    drive(1, 32'd73);
    drive(2, 32'd89);
    expect_out(32'd73, 1);
    expect_out(32'd89, 2);
    tick();
    check = '0;
    wait_alert("t2_wait", 5);
    chk("t2_s_a", 64'(s), 64'(1));
    chk("t2_sel_a", 64'(selected_sig), 64'(73));
    tick();
    chk("t2_alert_b", 64'(sig_alert), 64'(1));
    chk("t2_s_b", 64'(s), 64'(2));
    chk("t2_sel_b", 64'(selected_sig), 64'(89));
    tick();
    chk("t2_alert_end", 64'(sig_alert), 64'(0));
    chk("t2_ovf", 64'(overflow), 64'(0));

    // Back-pressure: ch0 fills, sixth push dropped.
    proc_ready = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      drive(0, WIDTH'(v));
      tick();
      if (v == 5) chk("t3_ovf_at_full", 64'(overflow), 64'(0));
    end
    check = '0;
    chk("t3_sel_held", 64'(selected_sig), 64'(1));
    chk("t3_alert_held", 64'(sig_alert), 64'(1));
    chk("t3_s_held", 64'(s), 64'(0));
    chk("t3_ovf", 64'(overflow), 64'(3'b001));
    chk("t3_empty", 64'(fifo_empty), 64'(3'b110));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", 64'(overflow), 64'(0));
    clr_ovf = 1'b1;
    drive(0, 32'd99);
    tick();
    clr_ovf = 1'b0;
    check = '0;
    chk("t3_set_wins", 64'(overflow), 64'(3'b001));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr2", 64'(overflow), 64'(0));

    // Push into a full ch0 on the same edge as its pop is accepted.
    for (int v = 1; v <= 5; v++) expect_out(WIDTH'(v), 0);
    expect_out(32'd7, 0);
    drive(0, 32'd7);
    proc_ready = 1'b1;
    tick();
    check = '0;
    chk("t6_ovf", 64'(overflow), 64'(0));
    chk("t6_sel", 64'(selected_sig), 64'(2));
    chk("t6_empty", 64'(fifo_empty), 64'(3'b110));
    repeat (6) tick();
    chk("t6_drained_alert", 64'(sig_alert), 64'(0));
    chk("t6_drained_empty", 64'(fifo_empty), 64'(3'b111));
    chk("t6_sb_done", 64'(sb_q.size()), 64'(0));

    // Fresh reset so round-robin restarts at ch0, then two entries per channel.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    drive(0, 32'd500); drive(1, 32'd800); drive(2, 32'd4);
    expect_out(32'd500, 0); expect_out(32'd800, 1); expect_out(32'd4, 2);
    tick();
    drive(0, 32'd501); drive(1, 32'd801); drive(2, 32'd5);
    expect_out(32'd501, 0); expect_out(32'd801, 1); expect_out(32'd5, 2);
    tick();
    check = '0;
    begin
      int n = 0;
      while (sb_q.size() > 3 && n < 20) begin
        tick();
        n++;
      end
    end
    chk("t4_progress", 64'(sb_q.size()), 64'(3));
    chk("t4_sel_next", 64'(selected_sig), 64'(501));
    chk("t4_s_next", 64'(s), 64'(0));

    // Asynchronous reset mid-drain.
    rst_n = 1'b0;
    #1;
    chk("t5_alert", 64'(sig_alert), 64'(0));
    chk("t5_sel", 64'(selected_sig), 64'(0));
    chk("t5_s", 64'(s), 64'(0));
    chk("t5_empty", 64'(fifo_empty), 64'(3'b111));
    chk("t5_ovf", 64'(overflow), 64'(0));
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_idle", 64'(sig_alert), 64'(0));
    drive(2, 32'd7);
    expect_out(32'd7, 2);
    tick();
    check = '0;
    wait_alert("t5_wait", 5);
    chk("t5_new_s", 64'(s), 64'(2));
    chk("t5_new_sel", 64'(selected_sig), 64'(7));
    repeat (2) tick();
    chk("t5_final_alert", 64'(sig_alert), 64'(0));
    chk("t5_sb_done", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/rxq_multi_arbiter.md
Name: rxq_multi_arbiter

Overview:
Parametrised receiver queue for a network node. It accepts instructions from NCH independent sources (default 3: ch0 right, ch1 left, ch2 self) and buffers each source in its own FIFO. A round-robin arbiter presents one instruction at a time to the processing logic through a valid/ready handshake, tagged with its source channel. Sits between the link receivers and the node's instruction processor.

Parameters:
WIDTH, 32, instruction width in bits
NCH, 3, number of input channels (2..8)
DEPTH, 4, entries per channel FIFO (power of 2, >=2)
SRC_W, 2, width of source tag; must satisfy 2^SRC_W >= NCH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
check  in  NCH  per-channel push strobe; bit i pushes in_sig slice i
in_sig  in  NCH*WIDTH  packed instructions; channel i = bits [i*WIDTH +: WIDTH]
proc_ready  in  1  consumer accepts the current output this cycle
clr_ovf  in  1  clears all overflow flags
selected_sig  out  WIDTH  instruction presented to the processor
sig_alert  out  1  selected_sig/s valid
s  out  SRC_W  source channel of selected_sig
overflow  out  NCH  sticky per-channel drop flag
fifo_empty  out  NCH  per-channel FIFO empty status

Behaviour:
- Reset (async, rst_n=0): all FIFOs empty, pointers 0, selected_sig=0, s=0, sig_alert=0, overflow=0, fifo_empty=all ones, RR pointer last_grant=NCH-1 (so ch0 wins first). Deassertion takes effect at the next clk edge.
- Push: at a rising edge with check[i]=1, the slice is written to FIFO i when it is not full, or when it is full but popped on the same edge. Otherwise the data is dropped and overflow[i] is set.
- Overflow is sticky. clr_ovf=1 clears it. If clr_ovf and a new drop occur on the same edge, the set wins.
- Output register is loadable when sig_alert=0 or (sig_alert=1 and proc_ready=1).
- When loadable and any FIFO is non-empty (state before this edge's pushes): the arbiter grants the first non-empty channel searching cyclically from last_grant+1. That FIFO's head is popped into selected_sig, s=grant index, sig_alert=1, last_grant=grant.
- When loadable and all FIFOs are empty: sig_alert goes to 0. selected_sig and s hold their last value.
- sig_alert=1 with proc_ready=0: selected_sig, s and sig_alert hold unchanged; FIFOs continue accepting pushes.
- Latency: push at edge k results in sig_alert=1 after edge k+1 at the earliest (FIFO write, then load).
- Throughput: one instruction per cycle with proc_ready held high.
- Simultaneous pushes on all channels in one cycle are all accepted when there is space.
- FIFO pointers wrap modulo DEPTH. Full/empty use an extra pointer bit. Occupancy never exceeds DEPTH.
- Unused codes of s (>= NCH) are never driven.

Optional Feature:
Macro RXQ_BYPASS_EN.
- Defined: when the output register is loadable and all FIFOs are empty, the round-robin winner among this edge's check bits loads directly into selected_sig on that same edge. Latency becomes 1 edge. The other simultaneous pushes enqueue normally and last_grant updates.
- Undefined: no bypass; latency is always at least 2 edges.

Test Plan:
1. ch0 pushes 42 once, proc_ready=1 → after 2nd edge: sig_alert=1, selected_sig=42, s=0; next edge: sig_alert=0. With RXQ_BYPASS_EN the valid output appears after the 1st edge.
2. ch1=73 and ch2=89 pushed together, proc_ready=1 → outputs 73/s=1 then 89/s=2 on consecutive cycles; no overflow.
3. proc_ready=0, DEPTH=4, ch0 pushes 1..6 on consecutive cycles → selected_sig=1 held; FIFO holds 2..5; 6 is dropped; overflow=3'b001. Then clr_ovf → overflow=0.
4. All channels hold 2 entries each (right 500,501; left 800,801; self 4,5), proc_ready=1 → output order 500,800,4,501,801,5 with s=0,1,2,0,1,2.
5. rst_n pulsed low mid-drain of scenario 4 → outputs reset immediately without a clock edge; after release, an empty queue gives sig_alert=0 and a new ch2 push of 7 yields s=2, selected_sig=7.
6. ch0 full with proc_ready=1, and a push on ch0 in the same cycle as its pop → push accepted, overflow stays 0.
